des_key_schedule: RTL and testbench

//  Upstream of the DES round datapath: turns one 64-bit DES key into the 16 48-bit round

---
 rtl/des_pkg.sv | 39 +++
 rtl/des_key_schedule_if.sv | 20 ++
 rtl/des_key_round.sv | 22 ++
 rtl/des_key_schedule.sv | 135 +++++++++++++
 tb/tb_des_key_schedule.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation/shift tables, FSM state type and helpers.
// Bit numbering follows FIPS 46-3: table entry 1 addresses the MSB of the source vector.
package des_pkg;
   localparam int ROUNDS   = 16;
   localparam int SUBKEY_W = 48;

   typedef enum logic [1:0] {IDLE, LOAD, GEN, STREAM} des_ks_state_t;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam logic [1:0] SHIFT [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   // Parity bits (8,16,..,64) never appear in PC1, so they drop out here.
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
      return r;
   endfunction

   function automatic logic [SUBKEY_W-1:0] pc2(input logic [55:0] cd);
      logic [SUBKEY_W-1:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
      return r;
   endfunction
endpackage

// File: rtl/des_key_schedule_if.sv
// Request / subkey-stream bundle between the key schedule and its requester/consumer.
interface des_key_schedule_if;
   import des_pkg::*;

   logic                start;
   logic [63:0]         key_in;
   logic                decrypt_en;
   logic                busy;
   logic                sk_valid;
   logic                sk_ready;
   logic [SUBKEY_W-1:0] sk_data;
   logic [3:0]          sk_round;
   logic                sk_last;
   logic                done;

   modport master (output start, key_in, decrypt_en, sk_ready,
                   input  busy, sk_valid, sk_data, sk_round, sk_last, done);
   modport slave  (input  start, key_in, decrypt_en, sk_ready,
                   output busy, sk_valid, sk_data, sk_round, sk_last, done);
endinterface

// File: rtl/des_key_round.sv
// One key-schedule step: rotate the C/D halves left by 1 or 2 and derive the PC-2 subkey.
module des_key_round
   import des_pkg::*;
(
   input  logic [27:0]         c_in,
   input  logic [27:0]         d_in,
   input  logic [1:0]          shift,
   output logic [27:0]         c_out,
   output logic [27:0]         d_out,
   output logic [SUBKEY_W-1:0] subkey
);
   always_comb begin
      if (shift == 2'd2) begin
         c_out = {c_in[25:0], c_in[27:26]};
         d_out = {d_in[25:0], d_in[27:26]};
      end else begin
         c_out = {c_in[26:0], c_in[27]};
         d_out = {d_in[26:0], d_in[27]};
      end
      subkey = pc2({c_out, d_out});
   end
endmodule

// File: rtl/des_key_schedule.sv
// Expands one DES key into 16 subkeys (one per cycle) and streams them in encrypt or
// decrypt order over a valid/ready port.
module des_key_schedule #(
   parameter int ROUNDS   = 16,
   parameter int SUBKEY_W = 48
) (
   input  logic              clk,
   input  logic              reset,
   des_key_schedule_if.slave kif
);
   import des_pkg::*;

   des_ks_state_t       state_q, state_d;
   logic [63:0]         key_q, key_d;
   logic                dec_q, dec_d;
   logic [27:0]         c_q, c_d, d_q, d_d;
   logic [3:0]          n_q, n_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [SUBKEY_W-1:0] sk_data_q, sk_data_d;
   logic [3:0]          sk_round_q, sk_round_d;
   logic [SUBKEY_W-1:0] store_q [ROUNDS];
   logic [SUBKEY_W-1:0] store_d [ROUNDS];

   logic [27:0]         c_rot, d_rot;
   logic [SUBKEY_W-1:0] subkey;
   logic [55:0]         cd0;
   logic [3:0]          slot_nxt, idx_nxt;
   logic                xfer;

   des_key_round u_round (
      .c_in  (c_q),
      .d_in  (d_q),
      .shift (SHIFT[n_q]),
      .c_out (c_rot),
      .d_out (d_rot),
      .subkey(subkey)
   );

   assign cd0      = pc1(key_q);
   assign xfer     = (state_q == STREAM) && kif.sk_ready;
   // n_q doubles as the GEN round counter and the STREAM slot counter.
   assign slot_nxt = n_q + 4'd1;
   assign idx_nxt  = dec_q ? ~slot_nxt : slot_nxt;

   assign kif.busy     = busy_q;
   assign kif.done     = done_q;
   assign kif.sk_data  = sk_data_q;
   assign kif.sk_round = sk_round_q;
   assign kif.sk_valid = (state_q == STREAM);
   assign kif.sk_last  = (state_q == STREAM) && (n_q == 4'hF);

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      dec_d      = dec_q;
      c_d        = c_q;
      d_d        = d_q;
      n_d        = n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      sk_data_d  = sk_data_q;
      sk_round_d = sk_round_q;
      store_d    = store_q;
      case (state_q)
         IDLE: if (kif.start) begin
            key_d   = kif.key_in;
            dec_d   = kif.decrypt_en;
            busy_d  = 1'b1;
            state_d = LOAD;
         end
         LOAD: begin
            c_d     = cd0[55:28];
            d_d     = cd0[27:0];
            n_d     = 4'd0;
            state_d = GEN;
         end
         GEN: begin
            c_d          = c_rot;
            d_d          = d_rot;
            store_d[n_q] = subkey;
            n_d          = slot_nxt;
            if (n_q == 4'hF) begin
               // K16 is still in flight this cycle, so decrypt order bypasses the store.
               state_d    = STREAM;
               sk_round_d = dec_q ? 4'd15 : 4'd0;
               sk_data_d  = dec_q ? subkey : store_q[0];
            end
         end
         STREAM: if (xfer) begin
            if (n_q == 4'hF) begin
               state_d    = IDLE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               n_d        = 4'd0;
               sk_data_d  = '0;
               sk_round_d = 4'd0;
            end else begin
               n_d        = slot_nxt;
               sk_round_d = idx_nxt;
               sk_data_d  = store_q[idx_nxt];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         key_q      <= '0;
         dec_q      <= 1'b0;
         c_q        <= '0;
         d_q        <= '0;
         n_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sk_data_q  <= '0;
         sk_round_q <= '0;
         store_q    <= '{default: '0};
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         dec_q      <= dec_d;
         c_q        <= c_d;
         d_q        <= d_d;
         n_q        <= n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         sk_data_q  <= sk_data_d;
         sk_round_q <= sk_round_d;
         store_q    <= store_d;
      end
   end
endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: scoreboard of expected beats, checked at each transfer.
module tb_des_key_schedule;
   import des_pkg::*;

   localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
   localparam logic [63:0] PARITY = 64'h0101010101010101;

   typedef struct {
      logic [3:0]  r;
      logic [47:0] d;
      logic        last;
   } exp_t;

   logic [47:0] kexp [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

   logic clk, rst_n;
   bit   bp_en;
   int   vecs, errs;
   exp_t sb[$];

   des_key_schedule_if kif();
   des_key_schedule dut (.clk(clk), .reset(rst_n), .kif(kif.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_run(input logic dec);
      for (int s = 0; s < 16; s++) begin
         exp_t e;
         int   idx;
         idx    = dec ? 15 - s : s;
         e.r    = 4'(idx);
         e.d    = kexp[idx];
         e.last = (s == 15);
         sb.push_back(e);
      end
   endtask

   // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
   task automatic start_run(input logic [63:0] key, input logic dec);
      kif.start      = 1'b1;
      kif.key_in     = key;
      kif.decrypt_en = dec;
      push_run(dec);
      @(negedge clk);
      kif.start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (!kif.done && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", kif.done, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  kif.busy, 0);
      check({tag, "_valid"}, kif.sk_valid, 0);
      check({tag, "_last"},  kif.sk_last, 0);
      check({tag, "_done"},  kif.done, 0);
      check({tag, "_data"},  kif.sk_data, 0);
      check({tag, "_round"}, kif.sk_round, 0);
   endtask

   initial begin
      kif.sk_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         kif.sk_ready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   // Transfer monitor, stall-stability checks and the C16/D16 == C0/D0 property.
   logic        hold_v = 1'b0, hold_last = 1'b0, chk_rot = 1'b0;
   logic [47:0] hold_d = '0;
   logic [3:0]  hold_r = '0;
   logic [27:0] c0_s = '0, d0_s = '0;
   always @(negedge clk) begin
      if (chk_rot) begin
         check("c16_eq_c0", dut.c_q, c0_s);
         check("d16_eq_d0", dut.d_q, d0_s);
      end
      chk_rot = (dut.state_q == GEN) && (dut.n_q == 4'hF);
      if (dut.state_q == GEN && dut.n_q == 4'h0) begin
         c0_s = dut.c_q;
         d0_s = dut.d_q;
      end
      if (hold_v && kif.sk_valid) begin
         check("stall_data",  kif.sk_data, hold_d);
         check("stall_round", kif.sk_round, hold_r);
         check("stall_last",  kif.sk_last, hold_last);
      end
      hold_v    = kif.sk_valid && !kif.sk_ready;
      hold_d    = kif.sk_data;
      hold_r    = kif.sk_round;
      hold_last = kif.sk_last;
      if (kif.sk_valid && kif.sk_ready) begin
         vecs++;
         assert (sb.size() != 0) else begin
            errs++;
            $error("FAIL beat_unexpected: observed round %0d expected no beat", kif.sk_round);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("beat_round", kif.sk_round, e.r);
            check("beat_data",  kif.sk_data, e.d);
            check("beat_last",  kif.sk_last, e.last);
         end
      end
   end

   initial begin
      vecs           = 0;
      errs           = 0;
      bp_en          = 0;
      rst_n          = 1'b0;
      kif.start      = 1'b0;
      kif.key_in     = '0;
      kif.decrypt_en = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      // 1: encrypt order with exact latency
      start_run(KEY, 1'b0);
      check("t1_busy_c1", kif.busy, 1);
      check("t1_valid_c1", kif.sk_valid, 0);
      repeat (16) @(negedge clk);
      check("t1_valid_c17", kif.sk_valid, 0);
      @(negedge clk);
      check("t1_valid_c18", kif.sk_valid, 1);
      check("t1_round_c18", kif.sk_round, 0);
      check("t1_data_c18", kif.sk_data, 48'h1B02EFFC7072);
      repeat (15) @(negedge clk);
      check("t1_last_c33", kif.sk_last, 1);
      check("t1_round_c33", kif.sk_round, 15);
      check("t1_data_c33", kif.sk_data, 48'hCB3D8B0E17F5);
      @(negedge clk);
      check("t1_done_c34", kif.done, 1);
      check("t1_busy_c34", kif.busy, 0);
      check("t1_valid_c34", kif.sk_valid, 0);
      @(negedge clk);
      check("t1_done_c35", kif.done, 0);
      check("t1_sb_empty", sb.size(), 0);

      // 2: decrypt order
      start_run(KEY, 1'b1);
      wait_done(100);
      check("t2_sb_empty", sb.size(), 0);
      @(negedge clk);

      // 3: random backpressure
      bp_en = 1;
      start_run(KEY, 1'b0);
      wait_done(600);
      bp_en = 0;
      check("t3_sb_empty", sb.size(), 0);
      @(negedge clk);

      // 4: parity bits do not matter
      start_run(KEY ^ PARITY, 1'b0);
      wait_done(100);
      check("t4_sb_empty", sb.size(), 0);
      @(negedge clk);

      // 5: start while busy ignored; start in the done cycle accepted
      start_run(KEY, 1'b0);
      repeat (4) @(negedge clk);
      kif.start = 1'b1; kif.key_in = 64'hFEDCBA9876543210; kif.decrypt_en = 1'b1;
      @(negedge clk);
      kif.start = 1'b0;
      repeat (14) @(negedge clk);
      kif.start = 1'b1; kif.key_in = 64'h0F1E2D3C4B5A6978;
      @(negedge clk);
      kif.start = 1'b0;
      wait_done(100);
      check("t5_sb_empty_1", sb.size(), 0);
      start_run(KEY, 1'b0);
      check("t5_busy_restart", kif.busy, 1);
      wait_done(100);
      check("t5_sb_empty_2", sb.size(), 0);
      @(negedge clk);

      // 6: reset during GEN (cycle 10) and during STREAM (cycle 25)
      start_run(KEY, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6_gen");
      sb.delete();
      repeat (3) @(negedge clk);
      check("t6_gen_nodone", kif.done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      start_run(KEY, 1'b0);
      repeat (24) @(negedge clk);
      check("t6_pre_valid", kif.sk_valid, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6_stream");
      sb.delete();
      repeat (3) @(negedge clk);
      check("t6_stream_nodone", kif.done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      start_run(KEY, 1'b0);
      wait_done(100);
      check("t6_sb_empty", sb.size(), 0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
